dpa_photo_scaler: RTL and testbench

//  Parametrised photo-to-frame-buffer transfer engine for the photo album datapath.
//  It reads one square RGB photo from image memory, box-averages each NxN source block and

---
 rtl/dpa_photo_scaler.sv | 167 ++++++++++++++++
 tb/tb_dpa_photo_scaler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dpa_photo_scaler.sv
// Photo-to-frame-buffer box-average scaler: reads an (N*FB_DIM)^2 photo, writes FB_DIM^2 averaged pixels.
// Optional macro DPA_ROUND_EN selects round-half-up averaging instead of truncation.

module dpa_scaler_lane #(
  parameter int CH_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            acc_ld,
  input  logic            acc_add,
  input  logic            n1,
  input  logic [2:0]      shamt,
  input  logic [CH_W-1:0] q,
  output logic [CH_W-1:0] res
);
  localparam int SW = CH_W + 5;

  logic [CH_W+3:0] acc;
  logic [SW-1:0]   sum, adj, shd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          acc <= '0;
    else if (acc_ld)  acc <= (CH_W+4)'(q);
    else if (acc_add) acc <= acc + (CH_W+4)'(q);
  end

  // The block's final sample is still on the bus during the write cycle.
  always_comb begin
    sum = n1 ? SW'(q) : SW'(acc) + SW'(q);
`ifdef DPA_ROUND_EN
    adj = sum + ((SW'(1) << shamt) >> 1);
`else
    adj = sum;
`endif
    shd = adj >> shamt;
    res = (shd > SW'({CH_W{1'b1}})) ? {CH_W{1'b1}} : shd[CH_W-1:0];
  end
endmodule

module dpa_photo_scaler #(
  parameter int ADDR_W = 20,
  parameter int CH_W   = 8,
  parameter int NUM_CH = 3,
  parameter int FB_DIM = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      src_addr,
  input  logic [ADDR_W-1:0]      fb_addr,
  input  logic [1:0]             size_sel,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      IM_A,
  input  logic [NUM_CH*CH_W-1:0] IM_Q,
  output logic [NUM_CH*CH_W-1:0] IM_D,
  output logic                   IM_WEN
);
  localparam int FB_LOG = $clog2(FB_DIM);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                         st;
  logic [FB_LOG-1:0]              i, j;
  logic [3:0]                     cnt;
  logic [1:0]                     nl, nl_in;
  logic [ADDR_W-1:0]              src, fb;
  logic [NUM_CH-1:0][CH_W-1:0]    wr_data;
  logic [NUM_CH*CH_W-1:0]         d_hold;
  logic [3:0]                     last_cnt;
  logic                           acc_ld, acc_add, last_pix;

  // Source address of sample cnt (dy = cnt>>nl, dx = cnt mod N) of output pixel (pi,pj).
  function automatic logic [ADDR_W-1:0] rd_addr(input logic [ADDR_W-1:0] base,
                                                input logic [FB_LOG-1:0] pi, pj,
                                                input logic [3:0] c, input logic [1:0] n);
    logic [ADDR_W-1:0] row, col;
    row = (ADDR_W'(pj) << n) + (ADDR_W'(c) >> n);
    col = (ADDR_W'(pi) << n) + (ADDR_W'(c) & ((ADDR_W'(1) << n) - ADDR_W'(1)));
    return base + (row << (FB_LOG + int'(n))) + col;
  endfunction

  always_comb begin
    case (size_sel)
      2'd0:    nl_in = 2'd0;
      2'd2:    nl_in = 2'd2;
      default: nl_in = 2'd1;
    endcase
    last_cnt = 4'((5'd1 << {nl, 1'b0}) - 5'd1);
    acc_ld   = (st == RD) && (cnt == 4'd1);
    acc_add  = (st == RD) && (cnt > 4'd1);
    last_pix = (&i) && (&j);
    IM_D     = (st == WR) ? wr_data : d_hold;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    dpa_scaler_lane #(.CH_W(CH_W)) u_lane (
      .clk    (clk),
      .rst    (reset),
      .acc_ld (acc_ld),
      .acc_add(acc_add),
      .n1     (nl == 2'd0),
      .shamt  ({nl, 1'b0}),
      .q      (IM_Q[k*CH_W +: CH_W]),
      .res    (wr_data[k])
    );
  end

  // IM_A is registered, so every transition loads the address of the next cycle's access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st     <= IDLE;
      i      <= '0;
      j      <= '0;
      cnt    <= '0;
      nl     <= '0;
      src    <= '0;
      fb     <= '0;
      d_hold <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      IM_A   <= '0;
      IM_WEN <= 1'b1;
    end else begin
      case (st)
        IDLE: if (start) begin
          st   <= RD;
          src  <= src_addr;
          fb   <= fb_addr;
          nl   <= nl_in;
          i    <= '0;
          j    <= '0;
          cnt  <= '0;
          busy <= 1'b1;
          IM_A <= rd_addr(src_addr, '0, '0, 4'd0, nl_in);
        end
        RD: if (cnt == last_cnt) begin
          st     <= WR;
          IM_WEN <= 1'b0;
          IM_A   <= fb + ADDR_W'({j, i});
        end else begin
          cnt  <= cnt + 4'd1;
          IM_A <= rd_addr(src, i, j, cnt + 4'd1, nl);
        end
        WR: begin
          d_hold <= wr_data;
          IM_WEN <= 1'b1;
          if (last_pix) begin
            st   <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            st   <= RD;
            cnt  <= '0;
            i    <= i + 1'b1;
            if (&i) j <= j + 1'b1;
            IM_A <= rd_addr(src, i + 1'b1, (&i) ? j + 1'b1 : j, 4'd0, nl);
          end
        end
        default: begin
          done <= 1'b0;
          st   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dpa_photo_scaler.sv
// Scoreboard bench for dpa_photo_scaler: expected frame-buffer writes come from a block-average model.
module tb_dpa_photo_scaler;
  localparam int AW = 20;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW-1:0] src_addr, fb_addr;
  logic [1:0]    size_sel;
  logic          busy, done;
  logic [AW-1:0] IM_A;
  logic [23:0]   IM_Q, IM_D;
  logic          IM_WEN;

  always #5 clk = ~clk;

  dpa_photo_scaler #(.ADDR_W(AW), .CH_W(8), .NUM_CH(3), .FB_DIM(FD)) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .fb_addr(fb_addr),
    .size_sel(size_sel), .busy(busy), .done(done), .IM_A(IM_A), .IM_Q(IM_Q),
    .IM_D(IM_D), .IM_WEN(IM_WEN)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [23:0]   data;
    int            cyc;
  } wr_t;

  wr_t         wq[$];
  int          dq[$];
  logic [23:0] mem [0:(1<<AW)-1];
  int          cyc, checks, errors;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Average of the NxN source block for output pixel (i,j), addresses modulo 2^AW.
  function automatic logic [23:0] exp_pix(input logic [AW-1:0] s, input int n, input int i, input int j);
    logic [23:0]   r;
    logic [AW-1:0] a;
    int            sum;
    r = '0;
    for (int ch = 0; ch < 3; ch++) begin
      sum = 0;
      for (int dy = 0; dy < n; dy++)
        for (int dx = 0; dx < n; dx++) begin
          a = s + AW'((j*n + dy) * FD * n + i*n + dx);
          sum += int'(mem[a][ch*8 +: 8]);
        end
`ifdef DPA_ROUND_EN
      r[ch*8 +: 8] = 8'((sum + (n*n)/2) / (n*n));
`else
      r[ch*8 +: 8] = 8'(sum / (n*n));
`endif
    end
    return r;
  endfunction

  task automatic fill(input logic [AW-1:0] base, input int cnt, input bit ff);
    logic [AW-1:0] a;
    for (int k = 0; k < cnt; k++) begin
      a = base + AW'(k);
      mem[a] = ff ? 24'hFFFFFF : 24'($urandom);
    end
  endtask

  task automatic mon_step();
    wr_t e;
    int  ec;
    if (reset) return;
    if (!IM_WEN) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected addr=%h data=%h cyc=%0d", IM_A, IM_D, cyc);
      end else begin
        e = wq.pop_front();
        if (IM_A !== e.addr || IM_D !== e.data || cyc != e.cyc || busy !== 1'b1) begin
          errors++;
          $display("FAIL write got a=%h d=%h cyc=%0d busy=%b exp a=%h d=%h cyc=%0d busy=1",
                   IM_A, IM_D, cyc, busy, e.addr, e.data, e.cyc);
        end
      end
    end
    if (done === 1'b1) begin
      checks++;
      if (dq.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected cyc=%0d", cyc);
      end else begin
        ec = dq.pop_front();
        if (cyc != ec || busy !== 1'b0) begin
          errors++;
          $display("FAIL done got cyc=%0d busy=%b exp cyc=%0d busy=0", cyc, busy, ec);
        end
      end
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode 0: plain frame, 1: second start mid-frame, 2: reset during the 5th write
  task automatic run_job(input logic [AW-1:0] s, input logic [AW-1:0] f, input logic [1:0] sel, input int mode);
    int  n, nn, c, npix;
    wr_t e;
    n    = (sel == 2'd0) ? 1 : (sel == 2'd2) ? 4 : 2;
    nn   = n * n;
    c    = cyc;
    npix = (mode == 2) ? 4 : FD * FD;
    for (int p = 0; p < npix; p++) begin
      e.addr = f + AW'(p);
      e.data = exp_pix(s, n, p % FD, p / FD);
      e.cyc  = c + (p + 1) * (nn + 1);
      wq.push_back(e);
    end
    if (mode != 2) dq.push_back(c + FD*FD*(nn + 1) + 1);
    src_addr = s; fb_addr = f; size_sel = sel; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (mode == 1) begin
      wait_cyc(c + 7);
      fb_addr = f ^ 20'h04000; size_sel = 2'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (mode == 2) begin
      wait_cyc(c + 5 * (nn + 1));
      #1 reset = 1'b1;
      #1;
      check("rst_mid_wen", 32'(IM_WEN), 32'd1);
      check("rst_mid_busy", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      check("rst_mid_pending", 32'(wq.size()), 32'd0);
    end else begin
      wait_cyc(c + FD*FD*(nn + 1) + 2);
      check("job_writes_left", 32'(wq.size()), 32'd0);
      check("job_done_left", 32'(dq.size()), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; src_addr = '0; fb_addr = '0; size_sel = '0;
    IM_Q = '0; cyc = 0; checks = 0; errors = 0;
    fork
      forever begin
        @(posedge clk);
        cyc++;
        IM_Q <= mem[IM_A];
        if (!IM_WEN) mem[IM_A] = IM_D;
      end
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none
    for (int k = 0; k < (1 << AW); k++) mem[k] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_im_a", 32'(IM_A), 32'd0);
    check("rst_im_d", 32'(IM_D), 32'd0);
    check("rst_im_wen", 32'(IM_WEN), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    fill(20'h00100, 16, 1'b0);
    run_job(20'h00100, 20'h00800, 2'd0, 0);
    check("t1_copy_last", 32'(mem[20'h0080F]), 32'(mem[20'h0010F]));

    fill(20'h01000, 64, 1'b0);
    mem[20'h01000][7:0] = 8'd1; mem[20'h01001][7:0] = 8'd2;
    mem[20'h01008][7:0] = 8'd3; mem[20'h01009][7:0] = 8'd4;
    run_job(20'h01000, 20'h00900, 2'd1, 0);
`ifdef DPA_ROUND_EN
    check("t2_red_avg", 32'(mem[20'h00900][7:0]), 32'd3);
`else
    check("t2_red_avg", 32'(mem[20'h00900][7:0]), 32'd2);
`endif

    fill(20'h02000, 256, 1'b1);
    run_job(20'h02000, 20'h00A00, 2'd2, 0);
    check("t3_full_white", 32'(mem[20'h00A0F]), 32'h00FFFFFF);

    fill(20'h03000, 64, 1'b0);
    run_job(20'h03000, 20'h00B00, 2'd3, 1);

    fill(20'hFFFF8, 16, 1'b0);
    run_job(20'hFFFF8, 20'h00400, 2'd0, 0);
    check("t5_wrap_px8", 32'(mem[20'h00408]), 32'(mem[20'h00000]));

    run_job(20'h00100, 20'h00C00, 2'd0, 2);

    for (int r = 0; r < 4; r++) begin
      logic [AW-1:0] s;
      logic [1:0]    sel;
      s   = 20'h10000 + AW'(r * 20'h01000) + AW'($urandom_range(0, 255));
      sel = 2'($urandom_range(0, 3));
      fill(s, 256, 1'b0);
      run_job(s, 20'h20000 + AW'(r * 20'h00100), sel, 0);
    end

    check("end_writes_left", 32'(wq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
